// File: rtl/param_seq_alu.sv
// Sequential ALU: single-cycle add/sub/shift/inc/dec, iterative shift-add multiply
// and restoring divide, all behind an IDLE -> EXEC -> DONE handshake.
module param_seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHW-1:0]     shamt,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   remainder,
  output logic               carry_out,
  output logic               overflow,
  output logic               div_by_zero,
  output logic               illegal_op
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
                         OP_LSL = 4'd4, OP_LSR = 4'd5, OP_ASR = 4'd6, OP_ASL = 4'd7,
                         OP_INC = 4'd8, OP_DEC = 4'd9;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state;
  logic [3:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [SHW-1:0]     shamt_r;
  logic               cin_r;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     add_s, sub_s, mul_sum, div_sh, div_diff;
  logic               div_ge, iterative;
  logic [WIDTH-1:0]   s_res, s_rem;
  logic               s_co, s_ov, s_dz, s_ill;
  logic [2*WIDTH-1:0] mul_next, div_next, step_next;

  always_comb begin
    add_s = {1'b0, a_r} + {1'b0, b_r} + (WIDTH+1)'(cin_r);
    sub_s = {1'b0, a_r} + {1'b0, ~b_r} + (WIDTH+1)'(1);
    s_res = '0;
    s_rem = '0;
    s_co = 1'b0;
    s_ov = 1'b0;
    s_dz = 1'b0;
    s_ill = 1'b0;
    iterative = 1'b0;
    case (op_r)
      OP_ADD: begin
        s_res = add_s[WIDTH-1:0];
        s_co  = add_s[WIDTH];
        s_ov  = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (add_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        s_res = sub_s[WIDTH-1:0];
        s_co  = sub_s[WIDTH];
        s_ov  = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sub_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_MUL: iterative = 1'b1;
      OP_DIV: begin
        if (b_r == '0) begin
          s_res = '1;
          s_rem = a_r;
          s_dz  = 1'b1;
        end else begin
          iterative = 1'b1;
        end
      end
      OP_LSL, OP_ASL: s_res = a_r << shamt_r;
      OP_LSR: s_res = a_r >> shamt_r;
      OP_ASR: s_res = $signed(a_r) >>> shamt_r;
      OP_INC: begin
        s_res = a_r + WIDTH'(1);
        s_co  = &a_r;
        s_ov  = (a_r == SMAX);
      end
      OP_DEC: begin
        s_res = a_r - WIDTH'(1);
        s_co  = (a_r == '0);
        s_ov  = (a_r == SMIN);
      end
      default: s_ill = 1'b1;
    endcase

    // MUL: acc = {partial product, remaining multiplier bits}, shifted right each step.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_r} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    // DIV: acc = {partial remainder, dividend/quotient}, shifted left each step.
    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, b_r});
    div_diff = div_sh - {1'b0, b_r};
    div_next = div_ge ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                      : {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    step_next = (op_r == OP_MUL) ? mul_next : div_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      shamt_r <= '0;
      cin_r <= 1'b0;
      acc <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      remainder <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r <= op;
            a_r <= a;
            b_r <= b;
            shamt_r <= shamt;
            cin_r <= cin;
            acc <= {{WIDTH{1'b0}}, (op == OP_DIV) ? a : b};
            cnt <= CW'(WIDTH-1);
            busy <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (iterative) begin
            acc <= step_next;
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
              state <= DONE;
              done <= 1'b1;
              result <= (op_r == OP_MUL) ? step_next
                                         : {{WIDTH{1'b0}}, step_next[WIDTH-1:0]};
              remainder <= (op_r == OP_DIV) ? step_next[2*WIDTH-1:WIDTH] : '0;
              carry_out <= 1'b0;
              overflow <= 1'b0;
              div_by_zero <= 1'b0;
              illegal_op <= 1'b0;
            end
          end else begin
            state <= DONE;
            done <= 1'b1;
            result <= {{WIDTH{1'b0}}, s_res};
            remainder <= s_rem;
            carry_out <= s_co;
            overflow <= s_ov;
            div_by_zero <= s_dz;
            illegal_op <= s_ill;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_param_seq_alu.sv
// Scoreboard bench for param_seq_alu (WIDTH=16): driver pushes expected responses,
// a monitor pops and compares on each done pulse.
module tb_param_seq_alu;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [3:0]     op = '0;
  logic [W-1:0]   a = '0, b = '0;
  logic [3:0]     shamt = '0;
  logic           cin = 1'b0;
  logic           busy, done, carry_out, overflow, div_by_zero, illegal_op;
  logic [2*W-1:0] result;
  logic [W-1:0]   remainder;

  param_seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .shamt(shamt), .cin(cin), .busy(busy), .done(done), .result(result),
    .remainder(remainder), .carry_out(carry_out), .overflow(overflow),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [15:0] rem;
    logic [3:0]  flags;  // {carry_out, overflow, div_by_zero, illegal_op}
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("remainder", 64'(remainder), 64'(e.rem));
        check("flags", 64'({carry_out, overflow, div_by_zero, illegal_op}), 64'(e.flags));
        check("latency", 64'(cyc - e.start_cyc + 1), 64'(e.lat));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: got busy=1 expected busy=0 within 100 cycles");
  endtask

  // mode 0: normal, 1: pulse start while busy, 2: reset at MUL iteration 8.
  // Called on a negedge with the DUT idle, so start lands in the first IDLE cycle.
  task automatic issue(input logic [3:0] o, input logic [15:0] aa, input logic [15:0] bb,
                       input logic [3:0] sh, input logic c, input logic [31:0] r,
                       input logic [15:0] rm, input logic [3:0] fl, input int lat,
                       input int mode);
    exp_t e;
    op = o; a = aa; b = bb; shamt = sh; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    e.res = r; e.rem = rm; e.flags = fl; e.lat = lat; e.start_cyc = cyc;
    sb.push_back(e);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op = 4'($urandom); shamt = 4'($urandom); cin = 1'b1;
    @(negedge clk);
    check("busy_after_start", 64'(busy), 64'(1));
    if (mode == 1) begin
      repeat (2) @(negedge clk);
      op = 4'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (mode == 2) begin
      repeat (8) @(negedge clk);
      check("hold_prev_result", 64'(result), 64'(last_res));
      void'(sb.pop_back());
      rst_n = 1'b0;
      #1;
      check("abort_outputs", {8'(busy), 8'(done), 4'(carry_out), 4'(overflow),
                              4'(div_by_zero), 4'(illegal_op)}, 64'(0));
      check("abort_result", {16'(remainder), result}, 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      last_res = '0;
      return;
    end
    wait_idle();
    last_res = r;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_result", {16'(remainder), result}, 64'(0));
    check("reset_ctrl", {8'(busy), 8'(done), 4'(carry_out), 4'(overflow),
                         4'(div_by_zero), 4'(illegal_op)}, 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    //    op     a        b        sh    cin  result         rem      flags    lat
    issue(4'd0, 16'hFFFF, 16'h0001, 4'd0, 1'b0, 32'h0000_0000, 16'h0, 4'b1000, 2, 0);
    issue(4'd1, 16'h8000, 16'h0001, 4'd0, 1'b0, 32'h0000_7FFF, 16'h0, 4'b1100, 2, 0);
    issue(4'd1, 16'h0001, 16'h0002, 4'd0, 1'b0, 32'h0000_FFFF, 16'h0, 4'b0000, 2, 0);
    issue(4'd0, 16'h7FFF, 16'h0000, 4'd0, 1'b1, 32'h0000_8000, 16'h0, 4'b0100, 2, 0);
    issue(4'd2, 16'hFFFF, 16'hFFFF, 4'd0, 1'b0, 32'hFFFE_0001, 16'h0, 4'b0000, 17, 1);
    issue(4'd3, 16'd1000, 16'd7,    4'd0, 1'b0, 32'd142,       16'd6, 4'b0000, 17, 0);
    issue(4'd3, 16'h1234, 16'h0000, 4'd0, 1'b0, 32'h0000_FFFF, 16'h1234, 4'b0010, 2, 0);
    issue(4'd12, 16'h1234, 16'h5678, 4'd3, 1'b1, 32'h0,        16'h0, 4'b0001, 2, 0);
    issue(4'd6, 16'h8000, 16'h0000, 4'd15, 1'b0, 32'h0000_FFFF, 16'h0, 4'b0000, 2, 0);
    issue(4'd5, 16'h8000, 16'h0000, 4'd15, 1'b0, 32'h0000_0001, 16'h0, 4'b0000, 2, 0);
    issue(4'd4, 16'h00F1, 16'h0000, 4'd4, 1'b0, 32'h0000_0F10, 16'h0, 4'b0000, 2, 0);
    issue(4'd7, 16'h8001, 16'h0000, 4'd1, 1'b0, 32'h0000_0002, 16'h0, 4'b0000, 2, 0);
    issue(4'd8, 16'hFFFF, 16'h0000, 4'd0, 1'b0, 32'h0000_0000, 16'h0, 4'b1000, 2, 0);
    issue(4'd8, 16'h7FFF, 16'h0000, 4'd0, 1'b0, 32'h0000_8000, 16'h0, 4'b0100, 2, 0);
    issue(4'd9, 16'h0000, 16'h0000, 4'd0, 1'b0, 32'h0000_FFFF, 16'h0, 4'b1000, 2, 0);
    issue(4'd9, 16'h8000, 16'h0000, 4'd0, 1'b0, 32'h0000_7FFF, 16'h0, 4'b0100, 2, 0);
    issue(4'd2, 16'h1234, 16'h5678, 4'd0, 1'b0, 32'h0626_0060, 16'h0, 4'b0000, 17, 0);
    issue(4'd3, 16'hFFFF, 16'h0010, 4'd0, 1'b0, 32'h0000_0FFF, 16'hF, 4'b0000, 17, 0);
    issue(4'd2, 16'h00FF, 16'h0003, 4'd0, 1'b0, 32'h0000_02FD, 16'h0, 4'b0000, 17, 2);
    issue(4'd0, 16'd2,    16'd3,    4'd0, 1'b0, 32'd5,         16'h0, 4'b0000, 2, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
